haar_database_server: RTL



---
 rtl/haar_database_server.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/haar_database_server.sv
// Streams one stage's Haar classifier parameters from a synchronous ROM on request,
// tagging each word with tree/classifier/parameter indices and boundary flags.
module haar_database_server #(
  parameter int DATA_WIDTH_12            = 12,
  parameter int DATA_WIDTH_16            = 16,
  parameter int NUM_PARAM_PER_CLASSIFIER = 18,
  parameter int NUM_CLASSIFIER_PER_TREE  = 2,
  parameter int NUM_TREE                 = 3,
  parameter int STAGE_BASE_ADDR          = 0
) (
  input  logic                     clk_fpga,
  input  logic                     reset_fpga,
  input  logic                     i_database_request,
  input  logic                     i_restart,
  output logic                     o_mem_rd,
  output logic [DATA_WIDTH_16-1:0] o_mem_addr,
  input  logic [DATA_WIDTH_12-1:0] i_mem_data,
  output logic                     o_data_valid,
  output logic [DATA_WIDTH_12-1:0] o_data,
  output logic [DATA_WIDTH_12-1:0] o_index_database,
  output logic [DATA_WIDTH_12-1:0] o_index_classifier,
  output logic [DATA_WIDTH_12-1:0] o_index_tree,
  output logic                     o_end_single_classifier,
  output logic                     o_end_tree,
  output logic                     o_end_all_classifier,
  output logic                     o_end_database,
  output logic [1:0]               dbg_state
);

  localparam int TOTAL = NUM_TREE * NUM_CLASSIFIER_PER_TREE * NUM_PARAM_PER_CLASSIFIER;
  localparam int PW = (NUM_PARAM_PER_CLASSIFIER > 1) ? $clog2(NUM_PARAM_PER_CLASSIFIER) : 1;
  localparam int CW = (NUM_CLASSIFIER_PER_TREE > 1) ? $clog2(NUM_CLASSIFIER_PER_TREE) : 1;
  localparam int TW = (NUM_TREE > 1) ? $clog2(NUM_TREE) : 1;
  localparam int WW = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  localparam logic [PW-1:0] P_LAST = PW'(NUM_PARAM_PER_CLASSIFIER - 1);
  localparam logic [CW-1:0] C_LAST = CW'(NUM_CLASSIFIER_PER_TREE - 1);
  localparam logic [TW-1:0] T_LAST = TW'(NUM_TREE - 1);
  localparam logic [WW-1:0] W_LAST = WW'(TOTAL - 1);
  localparam logic [DATA_WIDTH_16-1:0] BASE = DATA_WIDTH_16'(STAGE_BASE_ADDR);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic [PW-1:0] p;
  logic [CW-1:0] c;
  logic [TW-1:0] t;
  logic [WW-1:0] w;

  logic          s1_valid;
  logic [PW-1:0] s1_p;
  logic [CW-1:0] s1_c;
  logic [TW-1:0] s1_t;
  logic          s1_esc;
  logic          s1_et;
  logic          s1_eall;

  logic p_last;
  logic c_last;
  logic t_last;

  // Handshake: a word is fetched in every cycle where the request is high and the
  // stage is not yet exhausted; there is no backpressure, the word appears exactly
  // two cycles later with o_data_valid high for one cycle.
  assign o_mem_rd   = i_database_request & ((state == S_IDLE) | (state == S_FETCH)) & ~i_restart;
  assign o_mem_addr = BASE + DATA_WIDTH_16'(w);
  assign dbg_state  = state;

  assign p_last = (p == P_LAST);
  assign c_last = (c == C_LAST);
  assign t_last = (t == T_LAST);

  always_ff @(posedge clk_fpga) begin
    if (reset_fpga) begin
      state                   <= S_IDLE;
      p                       <= '0;
      c                       <= '0;
      t                       <= '0;
      w                       <= '0;
      s1_valid                <= 1'b0;
      s1_p                    <= '0;
      s1_c                    <= '0;
      s1_t                    <= '0;
      s1_esc                  <= 1'b0;
      s1_et                   <= 1'b0;
      s1_eall                 <= 1'b0;
      o_data_valid            <= 1'b0;
      o_data                  <= '0;
      o_index_database        <= '0;
      o_index_classifier      <= '0;
      o_index_tree            <= '0;
      o_end_single_classifier <= 1'b0;
      o_end_tree              <= 1'b0;
      o_end_all_classifier    <= 1'b0;
      o_end_database          <= 1'b0;
    end else if (i_restart) begin
      // Squash in-flight tags; data/index outputs keep their last values.
      state                   <= S_IDLE;
      p                       <= '0;
      c                       <= '0;
      t                       <= '0;
      w                       <= '0;
      s1_valid                <= 1'b0;
      o_data_valid            <= 1'b0;
      o_end_single_classifier <= 1'b0;
      o_end_tree              <= 1'b0;
      o_end_all_classifier    <= 1'b0;
      o_end_database          <= 1'b0;
    end else begin
      s1_valid <= o_mem_rd;
      if (o_mem_rd) begin
        s1_p    <= p;
        s1_c    <= c;
        s1_t    <= t;
        s1_esc  <= p_last;
        s1_et   <= p_last & c_last;
        s1_eall <= p_last & c_last & t_last;
        // Nested odometer: parameter, then classifier, then tree.
        if (p_last) begin
          p <= '0;
          if (c_last) begin
            c <= '0;
            t <= t_last ? '0 : t + 1'b1;
          end else begin
            c <= c + 1'b1;
          end
        end else begin
          p <= p + 1'b1;
        end
        w     <= (w == W_LAST) ? '0 : w + 1'b1;
        state <= (w == W_LAST) ? S_DRAIN : S_FETCH;
      end

      o_data_valid            <= s1_valid;
      o_end_single_classifier <= s1_valid & s1_esc;
      o_end_tree              <= s1_valid & s1_et;
      o_end_all_classifier    <= s1_valid & s1_eall;
      if (s1_valid) begin
        o_data             <= i_mem_data;
        o_index_database   <= DATA_WIDTH_12'(s1_p);
        o_index_classifier <= DATA_WIDTH_12'(s1_c);
        o_index_tree       <= DATA_WIDTH_12'(s1_t);
      end
      if (s1_valid & s1_eall) begin
        state          <= S_DONE;
        o_end_database <= 1'b1;
      end
    end
  end

endmodule
